// File: rtl/pulse2wb.sv
// pulse2wb: measures high time (and optionally period) of an external pulse.
// Optional period counter enabled by defining PULSE2WB_PERIOD_EN.
module pulse2wb #(
   parameter int DSIZE = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_stb,
   input  logic             i_we,
   input  logic [1:0]       i_adr,
   input  logic [DSIZE-1:0] i_dat,
   input  logic             i_e,
   input  logic             i_pulse,
   output logic             o_ack,
   output logic [DSIZE-1:0] o_dat,
   output logic             o_irq
);

   localparam logic [DSIZE-1:0] MAX = '1;
   localparam logic [DSIZE-1:0] ONE = {{(DSIZE-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_HIGH,
      S_LOW
   } state_t;

   state_t           state_q;
   logic             s1_q;
   logic             s2_q;
   logic             sd_q;
   logic [2:0]       fill_q;
   logic [DSIZE-1:0] wcnt_q;
   logic [DSIZE-1:0] width_q;
   logic [DSIZE-1:0] dat_q;
   logic             ack_q;
   logic             irq_q;
   logic             valid_q;
   logic             ovf_q;

   logic             valid_d;
   logic             ovf_d;
   logic [DSIZE-1:0] dat_d;
   logic [DSIZE-1:0] wcnt_inc;
   logic [DSIZE-1:0] period_rd;
   logic             rise;
   logic             fall;
   logic             acc;
   logic             wr_stat;
   logic             wcap;
   logic             wsat;
   logic             psat;
   logic             unused_ok;

   // Edges only count once the pipe holds post-reset samples, so a pulse
   // already high across reset is never taken as a fresh rise.
   assign rise     = fill_q[2] & s2_q & ~sd_q;
   assign fall     = fill_q[2] & ~s2_q & sd_q;
   assign acc      = i_stb & ~ack_q;
   assign wr_stat  = acc & i_we & (i_adr == 2'd2);
   assign wcap     = i_e & (state_q == S_HIGH) & fall;
   assign wsat     = wcap & (wcnt_q == MAX);
   assign wcnt_inc = (wcnt_q == MAX) ? wcnt_q : wcnt_q + ONE;
   assign unused_ok = ^{i_dat, 1'b0};

`ifdef PULSE2WB_PERIOD_EN
   logic [DSIZE-1:0] pcnt_q;
   logic [DSIZE-1:0] period_q;
   logic             pcap;

   assign pcap      = i_e & (state_q != S_IDLE) & rise;
   assign psat      = pcap & (pcnt_q == MAX);
   assign period_rd = period_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pcnt_q   <= '0;
         period_q <= '0;
      end else if (!i_e || state_q == S_IDLE) begin
         pcnt_q <= (i_e && rise) ? ONE : '0;
      end else if (pcap) begin
         period_q <= pcnt_q;
         pcnt_q   <= ONE;
      end else if (pcnt_q != MAX) begin
         pcnt_q <= pcnt_q + ONE;
      end
   end
`else
   assign psat      = 1'b0;
   assign period_rd = '0;
`endif

   // A capture beats a same-cycle STATUS clear.
   always_comb begin
      valid_d = valid_q;
      ovf_d   = ovf_q;
      if (wr_stat) begin
         valid_d = 1'b0;
         ovf_d   = 1'b0;
      end
      if (wcap) valid_d = 1'b1;
      if (wsat || psat) ovf_d = 1'b1;
   end

   always_comb begin
      dat_d = dat_q;
      if (acc) begin
         case (i_adr)
            2'd0:    dat_d = width_q;
            2'd1:    dat_d = period_rd;
            2'd2:    dat_d = {{(DSIZE-2){1'b0}}, ovf_q, valid_q};
            default: dat_d = '0;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         sd_q    <= 1'b0;
         fill_q  <= '0;
         ack_q   <= 1'b0;
         dat_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         s1_q    <= i_pulse;
         s2_q    <= s1_q;
         sd_q    <= s2_q;
         fill_q  <= {fill_q[1:0], 1'b1};
         ack_q   <= acc;
         dat_q   <= dat_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         width_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         irq_q <= wcap;
         if (wcap) width_q <= wcnt_q;
         if (!i_e) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (rise) begin
                     state_q <= S_HIGH;
                     wcnt_q  <= ONE;
                  end
               end
               S_HIGH: begin
                  if (fall) state_q <= S_LOW;
                  else wcnt_q <= wcnt_inc;
               end
               S_LOW: begin
                  if (rise) begin
                     state_q <= S_HIGH;
                     wcnt_q  <= ONE;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  wcnt_q  <= '0;
               end
            endcase
         end
      end
   end

   assign o_ack = ack_q;
   assign o_dat = dat_q;
   assign o_irq = irq_q;

endmodule

// File: tb/tb_pulse2wb.sv
// tb_pulse2wb: directed bench for pulse2wb with a run-length reference model.
module tb_pulse2wb;

   localparam int DSIZE = 8;
   localparam int MAXV  = 255;
`ifdef PULSE2WB_PERIOD_EN
   localparam int PER_EXP = 150;
`else
   localparam int PER_EXP = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       stb;
   logic       we;
   logic [1:0] adr;
   logic [7:0] wdat;
   logic       e;
   logic       pulse;
   logic       ack;
   logic [7:0] rdat;
   logic       irq;

   int n_chk  = 0;
   int n_fail = 0;
   int irq_cnt = 0;

   pulse2wb #(.DSIZE(DSIZE)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_stb  (stb),
      .i_we   (we),
      .i_adr  (adr),
      .i_dat  (wdat),
      .i_e    (e),
      .i_pulse(pulse),
      .o_ack  (ack),
      .o_dat  (rdat),
      .o_irq  (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: pulse high/period run lengths in whole cycles
   bit m_live = 0;
   bit m_ack, m_irq, m_valid, m_ovf;
   int m_dat, m_width, m_period;
   int nsamp, hi_run, per_run;
   bit h1, h2, h3;

   function automatic int clip(input int v);
      return (v > MAXV) ? MAXV : v;
   endfunction

   function automatic int reg_val(input logic [1:0] a);
      case (a)
         2'd0:    return m_width;
         2'd1:    return m_period;
         2'd2:    return int'({m_ovf, m_valid});
         default: return 0;
      endcase
   endfunction

   always @(posedge clk) begin
      bit acc, wr, rise, fall, wcap, sat;
      if (rst) begin
         m_live = 1; m_ack = 0; m_dat = 0; m_irq = 0;
         m_width = 0; m_period = 0; m_valid = 0; m_ovf = 0;
         nsamp = 0; hi_run = -1; per_run = -1;
         h1 = 0; h2 = 0; h3 = 0;
      end else if (m_live) begin
         acc = stb && !m_ack;
         if (acc) m_dat = reg_val(adr);
         m_ack = acc;
         wr = acc && we && adr == 2'd2;
         wcap = 0;
         sat = 0;
         if (!e) begin
            hi_run = -1;
            per_run = -1;
         end else begin
            rise = nsamp >= 3 && h2 && !h3;
            fall = nsamp >= 3 && !h2 && h3;
            if (hi_run >= 0) hi_run++;
            if (per_run >= 0) per_run++;
            if (fall && hi_run >= 0) begin
               wcap = 1;
               m_width = clip(hi_run);
               if (hi_run >= MAXV) sat = 1;
               hi_run = -1;
            end
            if (rise) begin
`ifdef PULSE2WB_PERIOD_EN
               if (per_run >= 0) begin
                  m_period = clip(per_run);
                  if (per_run >= MAXV) sat = 1;
               end
`endif
               per_run = 0;
               hi_run = 0;
            end
         end
         if (wr) begin
            m_valid = 0;
            m_ovf = 0;
         end
         if (wcap) m_valid = 1;
         if (sat) m_ovf = 1;
         m_irq = wcap;
         h3 = h2; h2 = h1; h1 = pulse;
         if (nsamp < 3) nsamp++;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("ack", ack, m_ack);
         check("irq", irq, m_irq);
         check("dat", rdat, m_dat);
         if (irq === 1'b1) irq_cnt++;
      end
   end

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic bus(input logic w, input logic [1:0] a, output logic [7:0] d);
      stb = 1; we = w; adr = a; wdat = 8'h00;
      @(negedge clk);
      d = rdat;
      check("ack_first", ack, 1);
      @(negedge clk);
      check("ack_second", ack, 0);
      stb = 0; we = 0;
   endtask

   task automatic rd(input string name, input logic [1:0] a, input int exp);
      logic [7:0] d;
      bus(1'b0, a, d);
      check(name, d, exp);
   endtask

   task automatic wr_stat();
      logic [7:0] d;
      bus(1'b1, 2'd2, d);
   endtask

   task automatic pulse_hl(input int hi, input int lo);
      pulse = 1; cyc(hi);
      pulse = 0; cyc(lo);
   endtask

   initial begin
      int c0;
      rst = 1; stb = 0; we = 0; adr = 0; wdat = 0; e = 0; pulse = 0;
      cyc(3);
      rst = 0;
      cyc(2);
      rd("rst_width", 2'd0, 0);
      rd("rst_period", 2'd1, 0);
      rd("rst_status", 2'd2, 0);
      rd("rst_adr3", 2'd3, 0);

      e = 1; cyc(2);
      c0 = irq_cnt;
      repeat (3) pulse_hl(100, 50);
      check("irq_count3", irq_cnt - c0, 3);
      rd("width100", 2'd0, 100);
      rd("status_valid", 2'd2, 1);
      rd("period150", 2'd1, PER_EXP);

      pulse_hl(300, 20);
      rd("width_sat", 2'd0, 255);
      rd("status_ovf", 2'd2, 3);
      wr_stat();
      rd("status_clr", 2'd2, 0);
      rd("width_kept", 2'd0, 255);

      pulse = 1; cyc(30);
      pulse = 0; cyc(2);
      wr_stat();
      cyc(3);
      rd("status_cap_wins", 2'd2, 1);
      rd("width30", 2'd0, 30);

      c0 = irq_cnt;
      pulse = 1; cyc(10);
      e = 0; cyc(10);
      pulse = 0; cyc(5);
      check("no_irq_disabled", irq_cnt - c0, 0);
      rd("width_retained", 2'd0, 30);
      rd("status_retained", 2'd2, 1);
      e = 1; cyc(5);
      pulse_hl(9, 10);
      rd("width9", 2'd0, 9);

      c0 = irq_cnt;
      pulse = 1; cyc(20);
      rst = 1; cyc(1);
      rst = 0; cyc(20);
      pulse = 0; cyc(6);
      check("no_irq_after_rst", irq_cnt - c0, 0);
      rd("rst_mid_width", 2'd0, 0);
      rd("rst_mid_period", 2'd1, 0);
      rd("rst_mid_status", 2'd2, 0);
      pulse_hl(30, 10);
      check("irq_after_rst", irq_cnt - c0, 1);
      rd("width_post_rst", 2'd0, 30);
      rd("status_post_rst", 2'd2, 1);

      cyc(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
